// File: rtl/trng_capture_sched.sv
// Capture-path sequencer: source reset, guard delay, FIFO fill/drain, com handshake, periodic re-seed.
// Optional build macro TRNG_SCHED_FREERUN_EN removes the periodic re-seed and saturates the round counter.
module trng_capture_sched #(
    parameter int GUARD_CYCLES = 8,
    parameter int RESET_PERIOD = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_fifo_almost_full,
    input  logic                 i_fifo_almost_empty,
    input  logic [7:0]           i_fifo_dat,
    input  logic                 i_com_ready,
    output logic                 o_src_reset,
    output logic                 o_fifo_write,
    output logic                 o_fifo_read,
    output logic                 o_send,
    output logic [7:0]           o_data,
    output logic [CNT_WIDTH-1:0] o_round_cnt,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        SRC_RST    = 3'd0,
        GUARD      = 3'd1,
        FILL       = 3'd2,
        DRAIN_IDLE = 3'd3,
        READ       = 3'd4,
        LOAD       = 3'd5,
        SEND       = 3'd6,
        SETTLE     = 3'd7
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'(GUARD_CYCLES - 1);
`ifndef TRNG_SCHED_FREERUN_EN
    localparam logic [CNT_WIDTH-1:0] PERIOD     = CNT_WIDTH'(RESET_PERIOD);
`endif

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] guard_cnt_q, guard_cnt_d;
    logic [CNT_WIDTH-1:0] round_cnt_q, round_cnt_d;
    logic [CNT_WIDTH-1:0] round_inc;
    logic [7:0]           data_q, data_d;
    logic                 last_q, last_d;

    assign round_inc = round_cnt_q + CNT_ONE;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        round_cnt_d = round_cnt_q;
        data_d      = data_q;
        last_d      = last_q;

        case (state_q)
            SRC_RST: begin
                guard_cnt_d = '0;
                round_cnt_d = '0;
                state_d     = GUARD;
            end
            GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    guard_cnt_d = '0;
                    state_d     = FILL;
                end else begin
                    guard_cnt_d = guard_cnt_q + CNT_ONE;
                end
            end
            FILL: begin
                if (i_fifo_almost_full) state_d = DRAIN_IDLE;
            end
            DRAIN_IDLE: begin
                if (i_com_ready) state_d = READ;
            end
            READ: begin
                last_d  = i_fifo_almost_empty;
                state_d = LOAD;
            end
            LOAD: begin
                data_d  = i_fifo_dat;
                state_d = SEND;
            end
            SEND: begin
                if (!last_q) begin
                    state_d = SETTLE;
                end else begin
`ifdef TRNG_SCHED_FREERUN_EN
                    if (round_cnt_q != '1) round_cnt_d = round_inc;
                    state_d = FILL;
`else
                    // Counter reads 0 already in SRC_RST when the period is reached.
                    if (round_inc == PERIOD) begin
                        round_cnt_d = '0;
                        state_d     = SRC_RST;
                    end else begin
                        round_cnt_d = round_inc;
                        state_d     = FILL;
                    end
`endif
                end
            end
            SETTLE: begin
                // com's ready drops one cycle late, so it is not sampled here.
                state_d = DRAIN_IDLE;
            end
            default: state_d = SRC_RST;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (i_reset) begin
            state_q     <= SRC_RST;
            guard_cnt_q <= '0;
            round_cnt_q <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            round_cnt_q <= round_cnt_d;
            data_q      <= data_d;
            last_q      <= last_d;
        end
    end

    // Reset is synchronous, so outputs are masked by i_reset to show reset values immediately.
    assign o_src_reset  = i_reset | (state_q == SRC_RST);
    assign o_fifo_write = ~i_reset & (state_q == FILL);
    assign o_fifo_read  = ~i_reset & (state_q == READ);
    assign o_send       = ~i_reset & (state_q == SEND);
    assign o_data       = i_reset ? 8'h00 : data_q;
    assign o_round_cnt  = i_reset ? '0 : round_cnt_q;
    assign o_state      = i_reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_trng_capture_sched.sv
// Bench for trng_capture_sched: reactive FIFO/com environment, scoreboard of bytes, event-timing reference model.
module tb_trng_capture_sched;

    localparam int GUARD  = 8;
    localparam int PERIOD = 2;
    localparam int CW     = 16;
`ifdef TRNG_SCHED_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_fifo_almost_full = 1'b0;
    logic          i_fifo_almost_empty = 1'b0;
    logic [7:0]    i_fifo_dat = 8'h00;
    logic          i_com_ready = 1'b0;
    logic          o_src_reset, o_fifo_write, o_fifo_read, o_send;
    logic [7:0]    o_data;
    logic [CW-1:0] o_round_cnt;
    logic [2:0]    o_state;

    trng_capture_sched #(
        .GUARD_CYCLES(GUARD),
        .RESET_PERIOD(PERIOD),
        .CNT_WIDTH   (CW)
    ) dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_fifo_almost_full (i_fifo_almost_full),
        .i_fifo_almost_empty(i_fifo_almost_empty),
        .i_fifo_dat         (i_fifo_dat),
        .i_com_ready        (i_com_ready),
        .o_src_reset        (o_src_reset),
        .o_fifo_write       (o_fifo_write),
        .o_fifo_read        (o_fifo_read),
        .o_send             (o_send),
        .o_data             (o_data),
        .o_round_cnt        (o_round_cnt),
        .o_state            (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         due;
        bit         last;
    } sb_item_t;

    sb_item_t   sb[$];
    logic [7:0] mem[$];
    int         dir_caps[$] = '{5, 2, 1, 3};
    logic [7:0] dir_bytes[$] = '{8'hA5, 8'h3C};
    int         cap = 1;
    int         ready_pct = 100;
    int         stall_req = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_sends = 0;
    int         n_rounds = 0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int next_cap();
        if (dir_caps.size() > 0) return dir_caps.pop_front();
        return $urandom_range(1, 5);
    endfunction

    // Environment: behavioural FIFO with capacity cap, plus com ready generator.
    initial begin : env
        bit wr, rd, rst;
        int rc, stall_left;
        logic [7:0] b;
        stall_left = 0;
        cap = next_cap();
        forever begin
            @(negedge clk);
            wr  = o_fifo_write;
            rd  = o_fifo_read;
            rst = i_reset;
            rc  = cyc;
            @(posedge clk);
            #1;
            i_fifo_dat = 8'($urandom);
            if (rst) begin
                mem.delete();
                cap = next_cap();
            end else begin
                if (rd) begin
                    check("fifo_underflow", mem.size() > 0, mem.size(), 1);
                    if (mem.size() > 0) begin
                        b = mem.pop_front();
                        i_fifo_dat = b;
                        sb.push_back('{data: b, due: rc + 2, last: (mem.size() == 0)});
                        if (mem.size() == 0) cap = next_cap();
                    end
                end
                if (wr) begin
                    check("fifo_overflow", mem.size() < cap, mem.size(), cap);
                    if (dir_bytes.size() > 0) mem.push_back(dir_bytes.pop_front());
                    else mem.push_back(8'($urandom));
                end
            end
            i_fifo_almost_full  = (mem.size() == cap - 1);
            i_fifo_almost_empty = (mem.size() == 1);
            if (stall_req > 0) begin
                stall_left = stall_req;
                stall_req  = 0;
            end
            if (stall_left > 0) begin
                i_com_ready = 1'b0;
                stall_left--;
            end else begin
                i_com_ready = ($urandom_range(0, 99) < ready_pct);
            end
        end
    end

    // Monitor: reference model of event timing, pops the scoreboard on each send.
    initial begin : monitor
        int exp_src, exp_wr, fill_start, idle_from, idle_chk, rounds_m;
        bit fill_on, waiting, prev_ready, fill_now, exp_rd;
        sb_item_t it;
        exp_src = -1; exp_wr = -1; fill_start = -1; idle_from = -1; idle_chk = -1; rounds_m = 0;
        fill_on = 0; waiting = 0; prev_ready = 0;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                check("rst_src_reset", o_src_reset === 1'b1, 32'(o_src_reset), 1);
                check("rst_strobes", {o_fifo_write, o_fifo_read, o_send} === 3'b000,
                      32'({o_fifo_write, o_fifo_read, o_send}), 0);
                check("rst_regs", o_data === 8'h00 && o_round_cnt === '0 && o_state === 3'd0,
                      {o_data, o_round_cnt, 5'd0, o_state}, 0);
                sb.delete();
                exp_src = cyc + 1; exp_wr = -1; fill_start = -1; idle_chk = -1;
                fill_on = 0; waiting = 0; rounds_m = 0;
            end else begin
                if (o_src_reset || cyc == exp_src)
                    check("src_reset_time", o_src_reset && cyc == exp_src, 32'(o_src_reset), 32'(cyc == exp_src));
                if (o_src_reset) begin
                    exp_wr = cyc + 1 + GUARD;
                    fill_on = 0; waiting = 0; rounds_m = 0; fill_start = -1;
                end

                fill_now = fill_on || cyc == exp_wr || cyc == fill_start;
                if (cyc == exp_wr || cyc == fill_start) begin
                    fill_on = 1;
                    check("round_cnt", o_round_cnt == CW'(rounds_m), o_round_cnt, rounds_m);
                end
                if (o_fifo_write || fill_now)
                    check("fill_write", o_fifo_write == fill_now, 32'(o_fifo_write), 32'(fill_now));
                if (o_fifo_write && fill_now && i_fifo_almost_full) begin
                    fill_on = 0; waiting = 1; idle_from = cyc + 1; idle_chk = cyc + 1;
                end

                if (cyc == idle_chk) check("fill_stop_state", o_state == 3'd3, o_state, 3);

                exp_rd = waiting && (cyc - 1 >= idle_from) && prev_ready;
                if (o_fifo_read || exp_rd) begin
                    check("read_time", o_fifo_read == exp_rd, 32'(o_fifo_read), 32'(exp_rd));
                    waiting = 0;
                end

                if (o_send || (sb.size() > 0 && sb[0].due <= cyc)) begin
                    if (sb.size() == 0) begin
                        check("send_spurious", 1'b0, 32'(o_send), 0);
                    end else begin
                        it = sb.pop_front();
                        check("send_time", o_send && it.due == cyc, 32'(cyc), 32'(it.due));
                        if (o_send) begin
                            n_sends++;
                            check("send_data", o_data == it.data, o_data, it.data);
                        end
                        if (it.last) begin
                            n_rounds++;
                            if (!FREERUN && rounds_m + 1 == PERIOD) begin
                                rounds_m = 0;
                                exp_src = cyc + 1;
                            end else begin
                                if (rounds_m < (1 << CW) - 1) rounds_m++;
                                fill_start = cyc + 1;
                            end
                        end else begin
                            waiting = 1;
                            idle_from = cyc + 2;
                        end
                    end
                end
            end
            prev_ready = i_com_ready;
        end
    end

    task automatic wait_state(input logic [2:0] s);
        bit hit;
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (o_state == s && !i_reset) hit = 1;
        end
        check("wait_state_timeout", hit, 32'(hit), 1);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b0;

        ready_pct = 100;
        run_cycles(400);

        ready_pct = 70;
        run_cycles(1500);

        // Long ready stall while idle in the drain loop.
        ready_pct = 100;
        wait_state(3'd7);
        stall_req = 20;
        run_cycles(200);

        // Reset while a byte is in LOAD: the byte must be dropped.
        wait_state(3'd4);
        @(posedge clk);
        #1 i_reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 i_reset = 1'b0;

        ready_pct = 80;
        run_cycles(2500);

        check("sends_seen", n_sends > 40, n_sends, 41);
        check("rounds_seen", n_rounds >= 40, n_rounds, 40);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
